// File: rtl/rv32im_types.sv
// Shared RV32IM types for the branch reservation station.
//   op_b_jal / op_b_jalr / op_b_br : opcode constants (instr[6:0])
//   rob_tag_t                      : ROB tag, sized for the default ROB depth
//   branch_rs_entry_t              : one reservation-station slot
//   operand_need()                 : {needs_rs2, needs_rs1} decoded from the opcode
package rv32im_types;

  localparam logic [6:0] op_b_jal  = 7'b1101111;
  localparam logic [6:0] op_b_jalr = 7'b1100111;
  localparam logic [6:0] op_b_br   = 7'b1100011;

  // The entry tag fields follow the default ROB depth. A top built with
  // another ROB_DEPTH must change this value to match.
  localparam int rob_depth_def = 4;
  localparam int rob_tag_w     = $clog2(rob_depth_def);

  typedef logic [rob_tag_w-1:0] rob_tag_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    rob_tag_t    tag;
    logic        rs1_rdy;
    logic [31:0] rs1_v;
    rob_tag_t    rs1_tag;
    logic        rs2_rdy;
    logic [31:0] rs2_v;
    rob_tag_t    rs2_tag;
  } branch_rs_entry_t;

  // Bit 0: rs1 needed, bit 1: rs2 needed. JAL and non-branch opcodes need none.
  function automatic logic [1:0] operand_need(input logic [6:0] opcode);
    case (opcode)
      op_b_jalr: return 2'b01;
      op_b_br:   return 2'b11;
      default:   return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/rs_operand_wakeup.sv
// CDB snoop for one operand slot of one reservation-station entry.
//   valid/rdy/tag/v      : current state of the operand slot
//   cdb_valid/tag/data   : CDB broadcast
//   rdy_nxt/v_nxt        : operand state to register at the next edge
module rs_operand_wakeup #(
  parameter int TW = 2
) (
  input  logic          valid,
  input  logic          rdy,
  input  logic [TW-1:0] tag,
  input  logic [31:0]   v,
  input  logic          cdb_valid,
  input  logic [TW-1:0] cdb_tag,
  input  logic [31:0]   cdb_data,
  output logic          rdy_nxt,
  output logic [31:0]   v_nxt
);

  logic hit;

  // Only a pending operand listens; a ready one keeps its value even if the
  // same tag is broadcast again.
  assign hit     = valid && !rdy && cdb_valid && (tag == cdb_tag);
  assign rdy_nxt = rdy || hit;
  assign v_nxt   = hit ? cdb_data : v;

endmodule

// File: rtl/branch_rs_ctrl.sv
// In-order reservation station and issue controller for the branch/jump
// comparator. Buffers dispatched ops, snoops the CDB for operands, issues the
// head to the comparator and holds the registered result until granted.
// Ports:
//   clk, rst (async active-high), flush (sync squash)
//   disp_*  : dispatch request and operands; disp_ready = queue not full
//   cdb_in_*: CDB broadcast used for operand wakeup
//   comp_*  : issue strobe/operands out, comparator result in
//   res_*   : registered result, valid/ready handshake to the CDB arbiter
// Build option: define RS_BYPASS_EN to let a CDB broadcast in the dispatch
// cycle satisfy a pending operand of the op being dispatched.
module branch_rs_ctrl
  import rv32im_types::*;
#(
  parameter  int RS_DEPTH  = 4,
  parameter  int ROB_DEPTH = 4,
  localparam int TW        = $clog2(ROB_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          disp_valid,
  output logic          disp_ready,
  input  logic [31:0]   disp_instr,
  input  logic [31:0]   disp_pc,
  input  logic [31:0]   disp_imm,
  input  logic [TW-1:0] disp_rob_tag,
  input  logic          disp_rs1_rdy,
  input  logic [31:0]   disp_rs1_v,
  input  logic [TW-1:0] disp_rs1_tag,
  input  logic          disp_rs2_rdy,
  input  logic [31:0]   disp_rs2_v,
  input  logic [TW-1:0] disp_rs2_tag,
  input  logic          cdb_in_valid,
  input  logic [TW-1:0] cdb_in_tag,
  input  logic [31:0]   cdb_in_data,
  output logic          comp_issue,
  output logic [31:0]   comp_rs1_v,
  output logic [31:0]   comp_rs2_v,
  output logic [31:0]   comp_pc,
  output logic [31:0]   comp_imm,
  output logic [31:0]   comp_instr,
  output logic [TW-1:0] comp_tag,
  input  logic [31:0]   comp_cdb_data,
  input  logic [31:0]   comp_pc_next,
  input  logic          comp_resp,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [31:0]   res_data,
  output logic [TW-1:0] res_tag,
  output logic [31:0]   res_pc_next,
  output logic          res_mispredict
);

  localparam int PW = $clog2(RS_DEPTH);

  branch_rs_entry_t entries [RS_DEPTH];
  branch_rs_entry_t new_entry;

  logic [PW:0]   wr_ptr, rd_ptr, count;
  logic [PW-1:0] wr_idx, rd_idx;
  logic          full, push, pop, issue;
  logic [1:0]    need;

  logic [RS_DEPTH-1:0] w1_rdy, w2_rdy;
  logic [31:0]         w1_v [RS_DEPTH];
  logic [31:0]         w2_v [RS_DEPTH];

  assign wr_idx = wr_ptr[PW-1:0];
  assign rd_idx = rd_ptr[PW-1:0];

  // Slot availability comes from the registered count only, so a pop in the
  // same cycle never opens a slot for dispatch.
  assign full       = (count == (PW+1)'(RS_DEPTH));
  assign disp_ready = !full;
  assign push       = disp_valid && !full && !flush;

  assign issue = entries[rd_idx].valid && entries[rd_idx].rs1_rdy &&
                 entries[rd_idx].rs2_rdy && (!res_valid || res_ready) && !flush;
  assign pop   = issue;

  for (genvar g = 0; g < RS_DEPTH; g++) begin : g_wake
    rs_operand_wakeup #(.TW(TW)) u_rs1 (
      .valid     (entries[g].valid),
      .rdy       (entries[g].rs1_rdy),
      .tag       (entries[g].rs1_tag),
      .v         (entries[g].rs1_v),
      .cdb_valid (cdb_in_valid),
      .cdb_tag   (cdb_in_tag),
      .cdb_data  (cdb_in_data),
      .rdy_nxt   (w1_rdy[g]),
      .v_nxt     (w1_v[g])
    );
    rs_operand_wakeup #(.TW(TW)) u_rs2 (
      .valid     (entries[g].valid),
      .rdy       (entries[g].rs2_rdy),
      .tag       (entries[g].rs2_tag),
      .v         (entries[g].rs2_v),
      .cdb_valid (cdb_in_valid),
      .cdb_tag   (cdb_in_tag),
      .cdb_data  (cdb_in_data),
      .rdy_nxt   (w2_rdy[g]),
      .v_nxt     (w2_v[g])
    );
  end

  always_comb begin
    new_entry         = '0;
    need              = operand_need(disp_instr[6:0]);
    new_entry.valid   = 1'b1;
    new_entry.instr   = disp_instr;
    new_entry.pc      = disp_pc;
    new_entry.imm     = disp_imm;
    new_entry.tag     = disp_rob_tag;
    new_entry.rs1_rdy = !need[0] || disp_rs1_rdy;
    new_entry.rs1_v   = disp_rs1_v;
    new_entry.rs1_tag = disp_rs1_tag;
    new_entry.rs2_rdy = !need[1] || disp_rs2_rdy;
    new_entry.rs2_v   = disp_rs2_v;
    new_entry.rs2_tag = disp_rs2_tag;
`ifdef RS_BYPASS_EN
    if (!new_entry.rs1_rdy && cdb_in_valid && (disp_rs1_tag == cdb_in_tag)) begin
      new_entry.rs1_rdy = 1'b1;
      new_entry.rs1_v   = cdb_in_data;
    end
    if (!new_entry.rs2_rdy && cdb_in_valid && (disp_rs2_tag == cdb_in_tag)) begin
      new_entry.rs2_rdy = 1'b1;
      new_entry.rs2_v   = cdb_in_data;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RS_DEPTH; i++) entries[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      for (int i = 0; i < RS_DEPTH; i++) entries[i].valid <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        entries[i].rs1_rdy <= w1_rdy[i];
        entries[i].rs1_v   <= w1_v[i];
        entries[i].rs2_rdy <= w2_rdy[i];
        entries[i].rs2_v   <= w2_v[i];
      end
      if (pop)  entries[rd_idx].valid <= 1'b0;
      // push never targets the head slot while it pops: that needs a full queue
      if (push) entries[wr_idx] <= new_entry;
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    comp_issue = 1'b0;
    comp_rs1_v = '0;
    comp_rs2_v = '0;
    comp_pc    = '0;
    comp_imm   = '0;
    comp_instr = '0;
    comp_tag   = '0;
    if (issue) begin
      comp_issue = 1'b1;
      comp_rs1_v = entries[rd_idx].rs1_v;
      comp_rs2_v = entries[rd_idx].rs2_v;
      comp_pc    = entries[rd_idx].pc;
      comp_imm   = entries[rd_idx].imm;
      comp_instr = entries[rd_idx].instr;
      comp_tag   = entries[rd_idx].tag;
    end
  end

  // Result register: an issue with comp_resp refills it even while it drains,
  // giving one op per cycle; non-branch ops pop without producing a result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid      <= 1'b0;
      res_data       <= '0;
      res_tag        <= '0;
      res_pc_next    <= '0;
      res_mispredict <= 1'b0;
    end else if (flush) begin
      res_valid <= 1'b0;
    end else if (issue && comp_resp) begin
      res_valid      <= 1'b1;
      res_data       <= comp_cdb_data;
      res_tag        <= comp_tag;
      res_pc_next    <= comp_pc_next;
      res_mispredict <= (comp_pc_next != comp_pc + 32'd4);
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_rs_ctrl.sv
module tb_branch_rs_ctrl;
  import rv32im_types::*;

  localparam int RS_DEPTH  = 4;
  localparam int ROB_DEPTH = 4;
  localparam int TW        = $clog2(ROB_DEPTH);

  localparam logic [31:0] I_JAL  = 32'h0000_006F;
  localparam logic [31:0] I_JALR = 32'h0000_0067;
  localparam logic [31:0] I_BEQ  = 32'h0000_0063;
  localparam logic [31:0] I_BNE  = 32'h0000_1063;
  localparam logic [31:0] I_ADD  = 32'h0000_0033;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic          disp_valid, disp_ready;
  logic [31:0]   disp_instr, disp_pc, disp_imm;
  logic [TW-1:0] disp_rob_tag;
  logic          disp_rs1_rdy, disp_rs2_rdy;
  logic [31:0]   disp_rs1_v, disp_rs2_v;
  logic [TW-1:0] disp_rs1_tag, disp_rs2_tag;
  logic          cdb_in_valid;
  logic [TW-1:0] cdb_in_tag;
  logic [31:0]   cdb_in_data;
  logic          comp_issue;
  logic [31:0]   comp_rs1_v, comp_rs2_v, comp_pc, comp_imm, comp_instr;
  logic [TW-1:0] comp_tag;
  logic [31:0]   comp_cdb_data, comp_pc_next;
  logic          comp_resp;
  logic          res_valid, res_ready;
  logic [31:0]   res_data, res_pc_next;
  logic [TW-1:0] res_tag;
  logic          res_mispredict;

  typedef struct packed {
    logic [31:0]   data;
    logic [TW-1:0] tag;
    logic [31:0]   pc_next;
    logic          mis;
  } res_t;

  res_t sb[$];
  res_t mon_exp;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  branch_rs_ctrl #(.RS_DEPTH(RS_DEPTH), .ROB_DEPTH(ROB_DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_instr(disp_instr), .disp_pc(disp_pc), .disp_imm(disp_imm),
    .disp_rob_tag(disp_rob_tag),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_v(disp_rs1_v), .disp_rs1_tag(disp_rs1_tag),
    .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_v(disp_rs2_v), .disp_rs2_tag(disp_rs2_tag),
    .cdb_in_valid(cdb_in_valid), .cdb_in_tag(cdb_in_tag), .cdb_in_data(cdb_in_data),
    .comp_issue(comp_issue), .comp_rs1_v(comp_rs1_v), .comp_rs2_v(comp_rs2_v),
    .comp_pc(comp_pc), .comp_imm(comp_imm), .comp_instr(comp_instr), .comp_tag(comp_tag),
    .comp_cdb_data(comp_cdb_data), .comp_pc_next(comp_pc_next), .comp_resp(comp_resp),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_pc_next(res_pc_next), .res_mispredict(res_mispredict)
  );

  function automatic logic [31:0] next_pc(input logic [31:0] instr, pc, imm, rs1, rs2);
    logic taken;
    case (instr[6:0])
      op_b_jal:  return pc + imm;
      op_b_jalr: return (rs1 + imm) & ~32'd1;
      op_b_br: begin
        taken = instr[12] ? (rs1 != rs2) : (rs1 == rs2);
        return taken ? pc + imm : pc + 32'd4;
      end
      default:   return pc + 32'd4;
    endcase
  endfunction

  // Comparator unit model (environment, driven by the DUT's issue outputs)
  always_comb begin
    comp_resp     = comp_issue &&
                    (comp_instr[6:0] inside {op_b_jal, op_b_jalr, op_b_br});
    comp_cdb_data = comp_pc + 32'd4;
    comp_pc_next  = next_pc(comp_instr, comp_pc, comp_imm, comp_rs1_v, comp_rs2_v);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input logic [31:0] instr, pc, imm, rs1, rs2,
                            input logic [TW-1:0] tag);
    res_t r;
    r.data    = pc + 32'd4;
    r.tag     = tag;
    r.pc_next = next_pc(instr, pc, imm, rs1, rs2);
    r.mis     = (r.pc_next != pc + 32'd4);
    sb.push_back(r);
  endtask

  task automatic dispatch(input logic [31:0] instr, pc, imm, input logic [TW-1:0] tag,
                          input logic r1, input logic [31:0] v1, input logic [TW-1:0] t1,
                          input logic r2, input logic [31:0] v2, input logic [TW-1:0] t2);
    disp_valid   = 1'b1;
    disp_instr   = instr;
    disp_pc      = pc;
    disp_imm     = imm;
    disp_rob_tag = tag;
    disp_rs1_rdy = r1;
    disp_rs1_v   = v1;
    disp_rs1_tag = t1;
    disp_rs2_rdy = r2;
    disp_rs2_v   = v2;
    disp_rs2_tag = t2;
  endtask

  task automatic idle_disp();
    disp_valid = 1'b0;
  endtask

  // Scoreboard: every granted result is popped and compared in order
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      total_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL result_unexpected: got tag=%0d data=%h pc_next=%h, none expected",
                 res_tag, res_data, res_pc_next);
      end else begin
        mon_exp = sb.pop_front();
        if ({res_data, res_tag, res_pc_next, res_mispredict} !== mon_exp) begin
          $display("FAIL result: got data=%h tag=%0d pc_next=%h mis=%0d, want data=%h tag=%0d pc_next=%h mis=%0d",
                   res_data, res_tag, res_pc_next, res_mispredict,
                   mon_exp.data, mon_exp.tag, mon_exp.pc_next, mon_exp.mis);
        end else begin
          pass_cnt++;
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; res_ready = 1'b1;
    cdb_in_valid = 1'b0; cdb_in_tag = '0; cdb_in_data = '0;
    dispatch('0, '0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    idle_disp();
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({disp_ready, res_valid, comp_issue} !== 3'b100) begin
      $display("FAIL reset_flags: got ready/valid/issue=%b want 100", {disp_ready, res_valid, comp_issue});
    end else pass_cnt++;
    total_cnt++;
    if ({res_data, res_pc_next, res_tag, res_mispredict} !== '0) begin
      $display("FAIL reset_res: got data=%h pc_next=%h tag=%0d mis=%0d want 0",
               res_data, res_pc_next, res_tag, res_mispredict);
    end else pass_cnt++;
    total_cnt++;
    if ({comp_pc, comp_instr, comp_rs1_v, comp_tag} !== '0) begin
      $display("FAIL reset_comp: got pc=%h instr=%h rs1=%h tag=%0d want 0",
               comp_pc, comp_instr, comp_rs1_v, comp_tag);
    end else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_jal();
    dispatch(I_JAL, 32'h100, 32'h20, 2'd1, 1'b0, '0, '0, 1'b0, '0, '0);
    expect_res(I_JAL, 32'h100, 32'h20, '0, '0, 2'd1);
    total_cnt++;
    if (comp_issue !== 1'b0) begin
      $display("FAIL jal_no_early_issue: got %b want 0", comp_issue);
    end else pass_cnt++;
    tick();
    idle_disp();
    total_cnt++;
    if ({comp_issue, comp_pc, comp_imm, comp_tag} !== {1'b1, 32'h100, 32'h20, 2'd1}) begin
      $display("FAIL jal_issue: got issue=%b pc=%h imm=%h tag=%0d want 1/100/20/1",
               comp_issue, comp_pc, comp_imm, comp_tag);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if ({res_valid, res_data, res_pc_next, res_mispredict} !== {1'b1, 32'h104, 32'h120, 1'b1}) begin
      $display("FAIL jal_result: got v=%b data=%h pc_next=%h mis=%b want 1/104/120/1",
               res_valid, res_data, res_pc_next, res_mispredict);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if (res_valid !== 1'b0) begin
      $display("FAIL jal_drained: res_valid got %b want 0", res_valid);
    end else pass_cnt++;
  endtask

  task automatic test_beq_wakeup();
    logic [31:0] d;
    for (int k = 0; k < 2; k++) begin
      d = (k == 0) ? 32'd5 : 32'd6;
      dispatch(I_BEQ, 32'h200, 32'h40, 2'd3, 1'b0, '0, 2'd2, 1'b1, 32'd5, '0);
      expect_res(I_BEQ, 32'h200, 32'h40, d, 32'd5, 2'd3);
      tick();
      idle_disp();
      for (int c = 0; c < 2; c++) begin
        total_cnt++;
        if (comp_issue !== 1'b0) begin
          $display("FAIL beq_stall: cycle %0d got issue=%b want 0", c, comp_issue);
        end else pass_cnt++;
        if (c == 0) tick();
      end
      cdb_in_valid = 1'b1; cdb_in_tag = 2'd2; cdb_in_data = d;
      tick();
      cdb_in_valid = 1'b0;
      total_cnt++;
      if ({comp_issue, comp_rs1_v, comp_rs2_v} !== {1'b1, d, 32'd5}) begin
        $display("FAIL beq_wake_issue: got issue=%b rs1=%h rs2=%h want 1/%h/5",
                 comp_issue, comp_rs1_v, comp_rs2_v, d);
      end else pass_cnt++;
      tick();
      total_cnt++;
      if ({res_valid, res_mispredict} !== {1'b1, (k == 0)}) begin
        $display("FAIL beq_mispredict: got v=%b mis=%b want 1/%0d", res_valid, res_mispredict, (k == 0));
      end else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_non_branch();
    dispatch(I_ADD, 32'h280, 32'h0, 2'd0, 1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    idle_disp();
    total_cnt++;
    if (comp_issue !== 1'b1) begin
      $display("FAIL nonbranch_issue: got %b want 1", comp_issue);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if ({res_valid, comp_issue} !== 2'b00) begin
      $display("FAIL nonbranch_drop: got res_valid/issue=%b want 00", {res_valid, comp_issue});
    end else pass_cnt++;
  endtask

  task automatic fill_five(input logic push_exp);
    logic [31:0] pc, imm;
    for (int k = 0; k < 5; k++) begin
      pc  = 32'h400 + 32'(k) * 32'h10;
      imm = 32'h40 + 32'(k) * 32'h4;
      total_cnt++;
      if (disp_ready !== 1'b1) begin
        $display("FAIL fill_ready: op %0d got disp_ready=%b want 1", k, disp_ready);
      end else pass_cnt++;
      dispatch(I_JAL, pc, imm, TW'(k), 1'b0, '0, '0, 1'b0, '0, '0);
      if (push_exp) expect_res(I_JAL, pc, imm, '0, '0, TW'(k));
      tick();
    end
    idle_disp();
  endtask

  task automatic test_fill_drain();
    int n;
    res_ready = 1'b0;
    fill_five(1'b1);
    total_cnt++;
    if ({disp_ready, res_valid, comp_issue} !== 3'b010) begin
      $display("FAIL full_state: got ready/valid/issue=%b want 010", {disp_ready, res_valid, comp_issue});
    end else pass_cnt++;
    repeat (3) tick();
    total_cnt++;
    if ({res_valid, res_tag, comp_issue} !== {1'b1, 2'd0, 1'b0}) begin
      $display("FAIL hold_one: got v=%b tag=%0d issue=%b want 1/0/0", res_valid, res_tag, comp_issue);
    end else pass_cnt++;
    res_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    total_cnt++;
    if (n !== 5) begin
      $display("FAIL drain_rate: got %0d cycles for 5 results want 5", n);
    end else pass_cnt++;
    total_cnt++;
    if ({disp_ready, res_valid} !== 2'b10) begin
      $display("FAIL drain_end: got ready/valid=%b want 10", {disp_ready, res_valid});
    end else pass_cnt++;
  endtask

  task automatic test_in_order();
    dispatch(I_BNE, 32'h500, 32'h30, 2'd2, 1'b0, '0, 2'd1, 1'b1, 32'd7, '0);
    expect_res(I_BNE, 32'h500, 32'h30, 32'd7, 32'd7, 2'd2);
    tick();
    dispatch(I_JAL, 32'h600, 32'h100, 2'd3, 1'b0, '0, '0, 1'b0, '0, '0);
    expect_res(I_JAL, 32'h600, 32'h100, '0, '0, 2'd3);
    tick();
    idle_disp();
    total_cnt++;
    if (comp_issue !== 1'b0) begin
      $display("FAIL inorder_block: got issue=%b tag=%0d want 0", comp_issue, comp_tag);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if (comp_issue !== 1'b0) begin
      $display("FAIL inorder_block2: got issue=%b tag=%0d want 0", comp_issue, comp_tag);
    end else pass_cnt++;
    cdb_in_valid = 1'b1; cdb_in_tag = 2'd1; cdb_in_data = 32'd7;
    tick();
    cdb_in_valid = 1'b0;
    total_cnt++;
    if ({comp_issue, comp_tag} !== {1'b1, 2'd2}) begin
      $display("FAIL inorder_head: got issue=%b tag=%0d want 1/2", comp_issue, comp_tag);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if ({comp_issue, comp_tag} !== {1'b1, 2'd3}) begin
      $display("FAIL inorder_young: got issue=%b tag=%0d want 1/3", comp_issue, comp_tag);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if (comp_issue !== 1'b0) begin
      $display("FAIL inorder_empty: got issue=%b want 0", comp_issue);
    end else pass_cnt++;
    tick();
  endtask

  task automatic test_flush();
    res_ready = 1'b0;
    fill_five(1'b0);
    total_cnt++;
    if ({disp_ready, res_valid} !== 2'b01) begin
      $display("FAIL preflush: got ready/valid=%b want 01", {disp_ready, res_valid});
    end else pass_cnt++;
    flush = 1'b1;
    dispatch(I_JAL, 32'h700, 32'h8, 2'd1, 1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    flush = 1'b0;
    idle_disp();
    total_cnt++;
    if ({disp_ready, res_valid, comp_issue} !== 3'b100) begin
      $display("FAIL flush_full: got ready/valid/issue=%b want 100", {disp_ready, res_valid, comp_issue});
    end else pass_cnt++;
    res_ready = 1'b1;
    // dispatch into an empty queue during flush must also be discarded
    flush = 1'b1;
    dispatch(I_JAL, 32'h780, 32'h8, 2'd2, 1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    flush = 1'b0;
    idle_disp();
    total_cnt++;
    if ({comp_issue, res_valid} !== 2'b00) begin
      $display("FAIL flush_disp_drop: got issue/valid=%b want 00", {comp_issue, res_valid});
    end else pass_cnt++;
    tick();
  endtask

  task automatic test_dispatch_bypass();
    dispatch(I_JALR, 32'h300, 32'h11, 2'd1, 1'b0, '0, 2'd2, 1'b0, '0, '0);
    cdb_in_valid = 1'b1; cdb_in_tag = 2'd2; cdb_in_data = 32'h1000;
    expect_res(I_JALR, 32'h300, 32'h11, 32'h1000, '0, 2'd1);
    tick();
    idle_disp();
    cdb_in_valid = 1'b0;
`ifdef RS_BYPASS_EN
    total_cnt++;
    if ({comp_issue, comp_rs1_v} !== {1'b1, 32'h1000}) begin
      $display("FAIL bypass_issue: got issue=%b rs1=%h want 1/1000", comp_issue, comp_rs1_v);
    end else pass_cnt++;
`else
    for (int c = 0; c < 2; c++) begin
      total_cnt++;
      if (comp_issue !== 1'b0) begin
        $display("FAIL nobypass_stall: cycle %0d got issue=%b want 0", c, comp_issue);
      end else pass_cnt++;
      tick();
    end
    cdb_in_valid = 1'b1; cdb_in_tag = 2'd2; cdb_in_data = 32'h1000;
    tick();
    cdb_in_valid = 1'b0;
    total_cnt++;
    if ({comp_issue, comp_rs1_v} !== {1'b1, 32'h1000}) begin
      $display("FAIL nobypass_rebroadcast: got issue=%b rs1=%h want 1/1000", comp_issue, comp_rs1_v);
    end else pass_cnt++;
`endif
    repeat (2) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_jal();
    test_beq_wakeup();
    test_non_branch();
    test_fill_drain();
    test_in_order();
    test_flush();
    test_dispatch_bypass();
    total_cnt++;
    if (sb.size() !== 0) begin
      $display("FAIL scoreboard_leftover: got %0d pending results want 0", sb.size());
    end else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
